// File: rtl/gw2a_ddr_dq_sched_if.sv
// gw2a_ddr_dq_sched_if
// Bundles the request/data handshakes and the IOB lanes of the DQ direction
// scheduler so that requesters, IOB model and scheduler share one port.
//   master : requester + IOB side (drives valids, write data, IOB Q lanes)
//   slave  : the scheduler (drives readies, take, read data/tags, OEN/D lanes)
// Signals:
//   wr_valid_i/wr_ready_o/wr_data_i/wr_take_o : write-burst request and beats
//   rd_valid_i/rd_ready_o                     : read-burst request
//   rd_data_o/rd_data_valid_o/rd_last_o       : tagged read beats
//   iob_oen_o/iob_d_o/iob_q_i                 : IOB OEN, {D1,D0}, {Q1,Q0}
//   busy_o                                    : burst, read data or gap pending
interface gw2a_ddr_dq_sched_if #(
   parameter int WIDTH = 16
);
   logic             wr_valid_i;
   logic             wr_ready_o;
   logic [WIDTH-1:0] wr_data_i;
   logic             wr_take_o;
   logic             rd_valid_i;
   logic             rd_ready_o;
   logic [WIDTH-1:0] rd_data_o;
   logic             rd_data_valid_o;
   logic             rd_last_o;
   logic             iob_oen_o;
   logic [WIDTH-1:0] iob_d_o;
   logic [WIDTH-1:0] iob_q_i;
   logic             busy_o;

   modport master (
      output wr_valid_i, wr_data_i, rd_valid_i, iob_q_i,
      input  wr_ready_o, wr_take_o, rd_ready_o, rd_data_o, rd_data_valid_o,
             rd_last_o, iob_oen_o, iob_d_o, busy_o
   );

   modport slave (
      input  wr_valid_i, wr_data_i, rd_valid_i, iob_q_i,
      output wr_ready_o, wr_take_o, rd_ready_o, rd_data_o, rd_data_valid_o,
             rd_last_o, iob_oen_o, iob_d_o, busy_o
   );
endinterface

// File: rtl/gw2a_ddr_dq_sched.sv
// gw2a_ddr_dq_sched
// Direction scheduler for one shared bidirectional DDR DQ group. Arbitrates a
// write-burst and a read-burst requester round-robin, drives write beats onto
// the IOB D lanes, releases the bus for read windows, enforces turnaround gaps
// and tags returning read data with a fixed read latency.
// Ports:
//   clk_x1 : PCLK, all logic on its rising edge
//   reset  : synchronous, active-high
//   bus    : gw2a_ddr_dq_sched_if.slave (handshakes, read data, IOB lanes)
module gw2a_ddr_dq_sched #(
   parameter int WIDTH = 16,
   parameter int BURST = 4,
   parameter int RDLAT = 3,
   parameter int TURN  = 1
) (
   input logic                clk_x1,
   input logic                reset,
   gw2a_ddr_dq_sched_if.slave bus
);
   localparam int CW   = 5;
   localparam int TAGW = (RDLAT > 0) ? RDLAT : 1;
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] BURST_M1 = CW'(BURST - 1);
   // write->read gap: cycles in TURN before a read may be accepted
   localparam logic [CW-1:0] W2R_M1   = CW'((TURN > 0) ? (TURN - 1) : 0);
   // read->write gap also covers the read data still in flight
   localparam logic [CW-1:0] R2W_M1   = CW'(((RDLAT + TURN) > 0) ? (RDLAT + TURN - 1) : 0);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2,
      ST_TURN  = 2'd3
   } state_t;

   state_t          state_r, state_s;
   logic [CW-1:0]   cnt_r, cnt_s;        // cycles left in the current state
   logic            last_wr_r, last_wr_s; // last served direction was write
   logic            from_wr_r, from_wr_s; // TURN entered after a write burst
   logic            cnt_zero_s;
   logic            wr_elig_s, rd_elig_s;
   logic            pick_wr_s, pick_rd_s;
   logic            wr_acc_s, rd_acc_s;
   logic            take_s, win_s, win_last_s;
   logic            cap_v_s, cap_l_s;
   logic [TAGW-1:0] tag_v_r, tag_l_r;
   logic            oen_r, dv_r, last_r;
   logic [WIDTH-1:0] d_r, rdata_r;

   assign cnt_zero_s = (cnt_r == CNT_ZERO);

   // Eligibility per state, round-robin pick and request acceptance
   always_comb begin
      wr_elig_s = 1'b0;
      rd_elig_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            wr_elig_s = 1'b1;
            rd_elig_s = 1'b1;
         end
         ST_WRITE: wr_elig_s = cnt_zero_s;
         ST_READ:  rd_elig_s = cnt_zero_s;
         ST_TURN: begin
            // same direction may continue; the opposite waits out the gap
            if (from_wr_r) begin
               wr_elig_s = 1'b1;
               rd_elig_s = cnt_zero_s;
            end else begin
               rd_elig_s = 1'b1;
               wr_elig_s = cnt_zero_s;
            end
         end
         default: begin
            wr_elig_s = 1'b0;
            rd_elig_s = 1'b0;
         end
      endcase
      // The pick ignores eligibility so a waiting opposite direction blocks
      // back-to-back grants instead of being starved.
      pick_rd_s  = bus.rd_valid_i & (~bus.wr_valid_i | last_wr_r);
      pick_wr_s  = bus.wr_valid_i & (~bus.rd_valid_i | ~last_wr_r);
      rd_acc_s   = pick_rd_s & rd_elig_s & ~reset;
      wr_acc_s   = pick_wr_s & wr_elig_s & ~reset;
      take_s     = wr_acc_s | ((state_r == ST_WRITE) & ~cnt_zero_s & ~reset);
      win_s      = (state_r == ST_READ);
      win_last_s = win_s & cnt_zero_s;
   end

   // Next-state and counter logic
   always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      last_wr_s = last_wr_r;
      from_wr_s = from_wr_r;
      if (wr_acc_s) begin
         state_s   = ST_WRITE;
         cnt_s     = BURST_M1;
         last_wr_s = 1'b1;
      end else if (rd_acc_s) begin
         state_s   = ST_READ;
         cnt_s     = BURST_M1;
         last_wr_s = 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: state_s = ST_IDLE;
            ST_WRITE: begin
               if (!cnt_zero_s) begin
                  cnt_s = cnt_r - CNT_ONE;
               end else if (TURN > 0) begin
                  state_s   = ST_TURN;
                  cnt_s     = W2R_M1;
                  from_wr_s = 1'b1;
               end else begin
                  state_s = ST_IDLE;
               end
            end
            ST_READ: begin
               if (!cnt_zero_s) begin
                  cnt_s = cnt_r - CNT_ONE;
               end else if ((RDLAT + TURN) > 0) begin
                  state_s   = ST_TURN;
                  cnt_s     = R2W_M1;
                  from_wr_s = 1'b0;
               end else begin
                  state_s = ST_IDLE;
               end
            end
            ST_TURN: begin
               if (!cnt_zero_s) begin
                  cnt_s = cnt_r - CNT_ONE;
               end else begin
                  state_s = ST_IDLE;
               end
            end
            default: begin
               state_s = ST_IDLE;
               cnt_s   = CNT_ZERO;
            end
         endcase
      end
   end

   // FSM state register; reset leaves "last served" as write
   always_ff @(posedge clk_x1) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         cnt_r     <= CNT_ZERO;
         last_wr_r <= 1'b1;
         from_wr_r <= 1'b0;
      end else begin
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         last_wr_r <= last_wr_s;
         from_wr_r <= from_wr_s;
      end
   end

   // Read tag pipeline: one valid/last tag per read-window cycle
   always_ff @(posedge clk_x1) begin
      if (reset) begin
         tag_v_r <= {TAGW{1'b0}};
         tag_l_r <= {TAGW{1'b0}};
      end else begin
         tag_v_r[0] <= win_s;
         tag_l_r[0] <= win_last_s;
         for (int k = 1; k < TAGW; k++) begin
            tag_v_r[k] <= tag_v_r[k-1];
            tag_l_r[k] <= tag_l_r[k-1];
         end
      end
   end

   // Tag whose Q data is on the lanes this cycle
   assign cap_v_s = (RDLAT > 0) ? tag_v_r[TAGW-1] : win_s;
   assign cap_l_s = (RDLAT > 0) ? tag_l_r[TAGW-1] : win_last_s;

   // Registered IOB drive and read capture; D is zero while released
   always_ff @(posedge clk_x1) begin
      if (reset) begin
         oen_r   <= 1'b1;
         d_r     <= {WIDTH{1'b0}};
         dv_r    <= 1'b0;
         last_r  <= 1'b0;
         rdata_r <= {WIDTH{1'b0}};
      end else begin
         oen_r   <= ~take_s;
         d_r     <= take_s ? bus.wr_data_i : {WIDTH{1'b0}};
         dv_r    <= cap_v_s;
         last_r  <= cap_l_s;
         rdata_r <= cap_v_s ? bus.iob_q_i : {WIDTH{1'b0}};
      end
   end

   assign bus.wr_ready_o      = wr_acc_s;
   assign bus.rd_ready_o      = rd_acc_s;
   assign bus.wr_take_o       = take_s;
   assign bus.iob_oen_o       = oen_r;
   assign bus.iob_d_o         = d_r;
   assign bus.rd_data_valid_o = dv_r;
   assign bus.rd_last_o       = last_r;
   assign bus.rd_data_o       = rdata_r;
   assign bus.busy_o          = (state_r != ST_IDLE) | (|tag_v_r);
endmodule

// File: tb/tb_gw2a_ddr_dq_sched.sv
// tb_gw2a_ddr_dq_sched
// Directed bench for gw2a_ddr_dq_sched with default parameters
// (WIDTH=16, BURST=4, RDLAT=3, TURN=1): a per-cycle vector table for a single
// write and a single read, then schedule sequences (alternation, back-to-back)
// checked against a timing model built from the expected accept cycles, and
// hand-written reset-abort sequences.
module tb_gw2a_ddr_dq_sched;
   localparam int WIDTH = 16;
   localparam int BURST = 4;
   localparam int RDLAT = 3;
   localparam int TURN  = 1;

   logic clk_x1 = 1'b0;
   logic reset  = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   w_exp[$];
   int   r_exp[$];

   always #5 clk_x1 = ~clk_x1;

   gw2a_ddr_dq_sched_if #(.WIDTH(WIDTH)) bus ();

   gw2a_ddr_dq_sched #(
      .WIDTH(WIDTH), .BURST(BURST), .RDLAT(RDLAT), .TURN(TURN)
   ) dut (
      .clk_x1(clk_x1),
      .reset (reset),
      .bus   (bus.slave)
   );

   typedef struct {
      logic        rst, wv, rv, chk;
      logic [15:0] wd, q;
      logic        wrdy, rrdy, take, oen, dv, last, busy;
      logic [15:0] d, rdata;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic rst, input logic wv, input logic [15:0] wd,
                               input logic rv, input logic [15:0] q, input logic chk,
                               input logic wrdy, input logic rrdy, input logic take,
                               input logic oen, input logic [15:0] d, input logic dv,
                               input logic [15:0] rdata, input logic last, input logic busy);
      vec_t v;
      v.rst = rst; v.wv = wv; v.wd = wd; v.rv = rv; v.q = q; v.chk = chk;
      v.wrdy = wrdy; v.rrdy = rrdy; v.take = take; v.oen = oen; v.d = d;
      v.dv = dv; v.rdata = rdata; v.last = last; v.busy = busy;
      return v;
   endfunction

   task automatic check1(input string name, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // one cycle: drive just after the edge, leave time for combinational settle
   task automatic cyc(input logic r, input logic wv, input logic rv);
      @(posedge clk_x1);
      #1;
      reset          = r;
      bus.wr_valid_i = wv;
      bus.rd_valid_i = rv;
      #1;
   endtask

   // Both requests held for the given spans; every output compared each cycle
   // with the schedule implied by the expected accept cycles in w_exp/r_exp.
   task automatic run_sched(input string tag, input int ncyc, input int wv_end, input int rv_end);
      logic        e_wrdy, e_rrdy, e_take, e_oen, e_dv, e_last;
      logic [15:0] e_d, e_rd;
      for (int c = 0; c < ncyc; c++) begin
         @(posedge clk_x1);
         #1;
         reset          = 1'b0;
         bus.wr_valid_i = (c < wv_end);
         bus.rd_valid_i = (c < rv_end);
         bus.wr_data_i  = 16'hD000 + 16'(c);
         bus.iob_q_i    = 16'hC000 + 16'(c);
         #1;
         e_wrdy = 1'b0; e_rrdy = 1'b0; e_take = 1'b0; e_oen = 1'b1;
         e_dv = 1'b0; e_last = 1'b0;
         foreach (w_exp[i]) begin
            if (c == w_exp[i]) e_wrdy = 1'b1;
            if (c >= w_exp[i] && c <= w_exp[i] + BURST - 1) e_take = 1'b1;
            if (c >= w_exp[i] + 1 && c <= w_exp[i] + BURST) e_oen = 1'b0;
         end
         foreach (r_exp[i]) begin
            if (c == r_exp[i]) e_rrdy = 1'b1;
            if (c >= r_exp[i] + RDLAT + 2 && c <= r_exp[i] + BURST + RDLAT + 1) e_dv = 1'b1;
            if (c == r_exp[i] + BURST + RDLAT + 1) e_last = 1'b1;
         end
         e_d  = e_oen ? 16'h0000 : 16'hD000 + 16'(c - 1);
         e_rd = e_dv ? 16'hC000 + 16'(c - 1) : 16'h0000;
         check1 ($sformatf("%s c%0d wr_ready", tag, c), bus.wr_ready_o, e_wrdy);
         check1 ($sformatf("%s c%0d rd_ready", tag, c), bus.rd_ready_o, e_rrdy);
         check1 ($sformatf("%s c%0d wr_take", tag, c), bus.wr_take_o, e_take);
         check1 ($sformatf("%s c%0d oen", tag, c), bus.iob_oen_o, e_oen);
         check16($sformatf("%s c%0d iob_d", tag, c), bus.iob_d_o, e_d);
         check1 ($sformatf("%s c%0d rd_valid", tag, c), bus.rd_data_valid_o, e_dv);
         check1 ($sformatf("%s c%0d rd_last", tag, c), bus.rd_last_o, e_last);
         check16($sformatf("%s c%0d rd_data", tag, c), bus.rd_data_o, e_rd);
      end
   endtask

   initial begin
      bus.wr_valid_i = 1'b0;
      bus.rd_valid_i = 1'b0;
      bus.wr_data_i  = 16'h0000;
      bus.iob_q_i    = 16'h0000;

      // rst wv wd rv q chk | wrdy rrdy take oen d dv rdata last busy
      vecs.push_back(mk(1,0,16'h0000,0,16'h0000,0, 0,0,0,1,16'h0000,0,16'h0000,0,0));
      vecs.push_back(mk(0,0,16'h0000,0,16'h0000,1, 0,0,0,1,16'h0000,0,16'h0000,0,0));
      vecs.push_back(mk(0,1,16'h1111,0,16'h0000,1, 1,0,1,1,16'h0000,0,16'h0000,0,0));
      vecs.push_back(mk(0,0,16'h2222,0,16'h0000,1, 0,0,1,0,16'h1111,0,16'h0000,0,1));
      vecs.push_back(mk(0,0,16'h3333,0,16'h0000,1, 0,0,1,0,16'h2222,0,16'h0000,0,1));
      vecs.push_back(mk(0,0,16'h4444,0,16'h0000,1, 0,0,1,0,16'h3333,0,16'h0000,0,1));
      vecs.push_back(mk(0,0,16'h0000,0,16'h0000,1, 0,0,0,0,16'h4444,0,16'h0000,0,1));
      vecs.push_back(mk(0,0,16'h0000,0,16'h0000,1, 0,0,0,1,16'h0000,0,16'h0000,0,1));
      vecs.push_back(mk(0,0,16'h0000,0,16'h0000,1, 0,0,0,1,16'h0000,0,16'h0000,0,0));
      vecs.push_back(mk(0,0,16'h0000,1,16'h0000,1, 0,1,0,1,16'h0000,0,16'h0000,0,0));
      vecs.push_back(mk(0,0,16'h0000,0,16'h0000,1, 0,0,0,1,16'h0000,0,16'h0000,0,1));
      vecs.push_back(mk(0,0,16'h0000,0,16'h0000,1, 0,0,0,1,16'h0000,0,16'h0000,0,1));
      vecs.push_back(mk(0,0,16'h0000,0,16'h0055,1, 0,0,0,1,16'h0000,0,16'h0000,0,1));
      vecs.push_back(mk(0,0,16'h0000,0,16'h00A0,1, 0,0,0,1,16'h0000,0,16'h0000,0,1));
      vecs.push_back(mk(0,0,16'h0000,0,16'h00A1,1, 0,0,0,1,16'h0000,1,16'h00A0,0,1));
      vecs.push_back(mk(0,0,16'h0000,0,16'h00A2,1, 0,0,0,1,16'h0000,1,16'h00A1,0,1));
      vecs.push_back(mk(0,0,16'h0000,0,16'h00A3,1, 0,0,0,1,16'h0000,1,16'h00A2,0,1));
      vecs.push_back(mk(0,0,16'h0000,0,16'h00EE,1, 0,0,0,1,16'h0000,1,16'h00A3,1,1));
      vecs.push_back(mk(0,0,16'h0000,0,16'h0000,1, 0,0,0,1,16'h0000,0,16'h0000,0,0));

      for (int i = 0; i < vecs.size(); i++) begin
         @(posedge clk_x1);
         #1;
         reset          = vecs[i].rst;
         bus.wr_valid_i = vecs[i].wv;
         bus.wr_data_i  = vecs[i].wd;
         bus.rd_valid_i = vecs[i].rv;
         bus.iob_q_i    = vecs[i].q;
         #1;
         if (vecs[i].chk) begin
            check1 ($sformatf("vec%0d wr_ready", i), bus.wr_ready_o, vecs[i].wrdy);
            check1 ($sformatf("vec%0d rd_ready", i), bus.rd_ready_o, vecs[i].rrdy);
            check1 ($sformatf("vec%0d wr_take", i), bus.wr_take_o, vecs[i].take);
            check1 ($sformatf("vec%0d oen", i), bus.iob_oen_o, vecs[i].oen);
            check16($sformatf("vec%0d iob_d", i), bus.iob_d_o, vecs[i].d);
            check1 ($sformatf("vec%0d rd_valid", i), bus.rd_data_valid_o, vecs[i].dv);
            check16($sformatf("vec%0d rd_data", i), bus.rd_data_o, vecs[i].rdata);
            check1 ($sformatf("vec%0d rd_last", i), bus.rd_last_o, vecs[i].last);
            check1 ($sformatf("vec%0d busy", i), bus.busy_o, vecs[i].busy);
         end
      end

      // both requests held from reset: R, W(+8), R(+5), W, R, W, R
      cyc(1'b1, 1'b0, 1'b0);
      w_exp = '{8, 21, 34};
      r_exp = '{0, 13, 26, 39};
      run_sched("alt", 41, 41, 41);

      // three back-to-back writes: 12 continuous takes and driven cycles
      cyc(1'b1, 1'b0, 1'b0);
      w_exp = '{0, 4, 8};
      r_exp.delete();
      run_sched("b2bw", 16, 9, 0);

      // two back-to-back reads: 8 continuous read beats
      cyc(1'b1, 1'b0, 1'b0);
      w_exp.delete();
      r_exp = '{0, 4};
      run_sched("b2br", 14, 0, 5);

      // reset at beat 2 of a write, then a tie right after reset
      bus.wr_data_i = 16'hBEEF;
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      check1("rstw accept", bus.wr_ready_o, 1'b1);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b1);
      check1 ("rstw oen", bus.iob_oen_o, 1'b1);
      check16("rstw iob_d", bus.iob_d_o, 16'h0000);
      check1 ("rstw tie rd_ready", bus.rd_ready_o, 1'b1);
      check1 ("rstw tie wr_ready", bus.wr_ready_o, 1'b0);
      for (int c = 4; c <= 8; c++) begin
         cyc(1'b0, 1'b0, 1'b0);
         check1($sformatf("rstw c%0d wr_take", c), bus.wr_take_o, 1'b0);
         check1($sformatf("rstw c%0d oen", c), bus.iob_oen_o, 1'b1);
      end

      // reset between read accept and first data: stale beats are dropped
      bus.iob_q_i = 16'h1234;
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1);
      check1("rstr accept", bus.rd_ready_o, 1'b1);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b1);
      check1("rstr busy", bus.busy_o, 1'b0);
      check1("rstr oen", bus.iob_oen_o, 1'b1);
      check1("rstr tie rd_ready", bus.rd_ready_o, 1'b1);
      check1("rstr tie wr_ready", bus.wr_ready_o, 1'b0);
      for (int c = 5; c <= 12; c++) begin
         cyc(1'b0, 1'b0, 1'b0);
         check1 ($sformatf("rstr c%0d rd_valid", c), bus.rd_data_valid_o, (c >= 9) ? 1'b1 : 1'b0);
         check1 ($sformatf("rstr c%0d rd_last", c), bus.rd_last_o, (c == 12) ? 1'b1 : 1'b0);
         check16($sformatf("rstr c%0d rd_data", c), bus.rd_data_o, (c >= 9) ? 16'h1234 : 16'h0000);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/gw2a_ddr_dq_sched.md
# gw2a_ddr_dq_sched

Direction scheduler for one shared bidirectional DDR DQ group built from `gw2a_ddr_iob` instances. It sits between a write-burst requester and a read-burst requester on the `clk_x1` (PCLK) side and owns the IOB `OEN`, `{D1,D0}` and `{Q1,Q0}` lanes. It arbitrates the two requesters round-robin, drives write bursts onto the bus, and releases the bus for read bursts. It inserts read→write and write→read turnaround gaps and tags returning read data using a fixed read latency.

## Interface
Parameters:
- `WIDTH`, 16: data bits per `clk_x1` cycle, `{D1,D0}` / `{Q1,Q0}` concatenated across all IOBs. Must be even.
- `BURST`, 4: `clk_x1` beats per burst, range 1..16.
- `RDLAT`, 3: cycles from a read-window cycle until its data is present on `iob_q_i`, range 0..15.
- `TURN`, 1: extra idle bus cycles on every direction change, range 0..7.

Ports:
- `clk_x1` in 1: PCLK; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `wr_valid_i` in 1: write-burst request.
- `wr_ready_o` out 1: write request accepted this cycle when `wr_valid_i & wr_ready_o`.
- `wr_data_i` in WIDTH: write beat, sampled in every cycle where `wr_take_o` is high.
- `wr_take_o` out 1: write beat consumed this cycle.
- `rd_valid_i` in 1: read-burst request.
- `rd_ready_o` out 1: read request accepted this cycle when `rd_valid_i & rd_ready_o`.
- `rd_data_o` out WIDTH: captured read beat.
- `rd_data_valid_o` out 1: `rd_data_o` is valid.
- `rd_last_o` out 1: final beat of a read burst; only high together with `rd_data_valid_o`.
- `iob_oen_o` out 1: to all IOB `OEN`; active-low output enable.
- `iob_d_o` out WIDTH: to the IOB `{D1,D0}` lanes.
- `iob_q_i` in WIDTH: from the IOB `{Q1,Q0}` lanes.
- `busy_o` out 1: high when a burst is in flight, read data is pending, or a turnaround is in progress.

## Operation
- States:
  - `IDLE`: bus released.
  - `WRITE`: driving.
  - `READ`: read window.
  - `TURN`: gap countdown.
- Acceptance: a request can be accepted in `IDLE`, or in the last beat of a same-direction burst (back-to-back). A direction change must go through `TURN`.
- Arbitration: `rd_ready_o` and `wr_ready_o` are never high together. If both requests are valid and eligible, grant the direction not served last. After reset, "last served" is write, so a read wins the first tie.
- Eligibility:
  - A write is eligible only when no read data is still due on the bus and the gap below has elapsed.
  - A read is eligible only after the post-write gap has elapsed.
  - An ineligible request is held (ready stays low). It is never dropped.
- Write burst accepted at cycle t:
  - `wr_take_o` is high in cycles t..t+BURST-1.
  - `wr_data_i` is registered to `iob_d_o`.
  - `iob_oen_o` is 0 in cycles t+1..t+BURST.
- Read burst accepted at cycle t:
  - The read window is cycles t+1..t+BURST, with `iob_oen_o` = 1.
  - A RDLAT-deep valid/last tag pipeline tracks each window cycle w.
  - `iob_q_i` is sampled at the end of cycle w+RDLAT and presented on `rd_data_o` in cycle w+RDLAT+1 with `rd_data_valid_o` = 1.
  - `rd_last_o` marks the beat from the final window cycle.
- Turnaround, write→read: at least TURN cycles with `iob_oen_o` = 1 between the last driven cycle and the first read-window cycle.
- Turnaround, read→write: the first driven cycle must come strictly after cycle (last window cycle + RDLAT + TURN).
- Idle bus: `iob_d_o` holds 0 whenever `iob_oen_o` = 1.

## Timing
- Reset values, applied the cycle after `reset` is sampled high:
  - state `IDLE`, last served = write.
  - `iob_oen_o` = 1; `iob_d_o`, `rd_data_o` = 0.
  - `wr_ready_o`, `rd_ready_o`, `wr_take_o`, `rd_data_valid_o`, `rd_last_o`, `busy_o` = 0.
  - Tag pipeline and turnaround counter cleared.
- Reset mid-burst: the burst aborts immediately, with no remaining `wr_take_o` and no pending read beats delivered. The bus is released in the next cycle.
- Ready signals are combinational from state, counters and the valid inputs. All `iob_*` and `rd_*` outputs are registered.
- Latency, write: accept at t → first driven beat at t+1.
- Latency, read: accept at t → first `rd_data_valid_o` at t+RDLAT+2; the last beat is at t+BURST+RDLAT+1.
- Minimum spacing between accepts:
  - Same direction: BURST cycles.
  - Write→read: BURST+TURN cycles.
  - Read→write: BURST+RDLAT+TURN cycles.
- Throughput: back-to-back same-direction bursts produce continuous `iob_oen_o` = 0 or continuous `rd_data_valid_o`, with no bubble.
- Simultaneous events:
  - A request arriving on the last beat of an opposite-direction burst is deferred, and the opposing burst's direction is recorded as last served.
  - `rd_valid_i` and `wr_valid_i` dropping before ready is legal.

## Test plan
- Single write, defaults: `wr_valid_i` with beats 0x1111..0x4444 → `wr_take_o` high for 4 cycles, then `iob_oen_o` = 0 for exactly 4 cycles with `iob_d_o` = 0x1111, 0x2222, 0x3333, 0x4444, then `iob_oen_o` = 1 and `iob_d_o` = 0.
- Single read, RDLAT=3: accept at t, drive `iob_q_i` = 0xA0+n at cycle t+1+n+3 → `rd_data_o` = 0xA0..0xA3 at t+5..t+8, `rd_last_o` only at t+8, `iob_oen_o` = 1 throughout.
- Write then read, requests held high together from reset: read is granted first; the write is granted at read accept +4+3+1 = +8 cycles. A second read is then held until write accept +5.
- Both requests continuously valid for 6 bursts → grants alternate R, W, R, W, R, W. No cycle has `iob_oen_o` = 0 overlapping a scheduled read window or pending RDLAT capture.
- Back-to-back writes (`wr_valid_i` held high for 3 bursts) → `iob_oen_o` = 0 for 12 consecutive cycles and `wr_take_o` high for 12 consecutive cycles.
- Reset asserted at beat 2 of a write and separately between read accept and first data → next cycle `iob_oen_o` = 1, no further `wr_take_o`/`rd_data_valid_o`, and the first post-reset tie is granted to read.
